// File: rtl/apb_timer_pkg.sv
// ---------------------------------------------------------------------------
// apb_timer_pkg
// Shared definitions for the APB timer: register byte offsets, the word
// indices decoded from paddr[7:2], CTRL/STATUS field positions, the FSM
// state encoding and a helper that packs the CTRL read-back word.
// No ports (package).
// ---------------------------------------------------------------------------
package apb_timer_pkg;

    // Register byte offsets
    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_LOAD   = 8'h04;
    localparam logic [7:0] OFF_VALUE  = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;

    // Word indices as seen on paddr[7:2]
    localparam logic [5:0] IDX_CTRL   = OFF_CTRL[7:2];
    localparam logic [5:0] IDX_LOAD   = OFF_LOAD[7:2];
    localparam logic [5:0] IDX_VALUE  = OFF_VALUE[7:2];
    localparam logic [5:0] IDX_STATUS = OFF_STATUS[7:2];

    // CTRL field positions
    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_MODE_BIT     = 1;
    localparam int CTRL_IE_BIT       = 2;
    localparam int CTRL_PRESCALE_LSB = 8;
    localparam int CTRL_PRESCALE_MSB = 15;

    // STATUS field positions
    localparam int STATUS_FLAG_BIT   = 0;

    // Timer FSM state encoding; RUN doubles as the CTRL.EN read-back
    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } timer_state_t;

    // Assemble the CTRL word; bits that are not fields read as zero
    function automatic logic [31:0] pack_ctrl(input logic       en,
                                              input logic       mode,
                                              input logic       ie,
                                              input logic [7:0] prescale);
        return {16'h0000, prescale, 5'b00000, ie, mode, en};
    endfunction

endpackage

// File: rtl/apb_timer_prescaler.sv
// ---------------------------------------------------------------------------
// apb_timer_prescaler
// 8-bit prescaler counter for the APB timer. While run is high the count
// advances every clock; when it equals prescale a one-cycle tick is issued
// and the count wraps to 0. start clears the count on the STOP->RUN edge.
// Only instantiated when APB_TIMER_PRESCALE_EN is defined.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   run       in   timer FSM is in RUN
//   start     in   timer FSM is leaving STOP for RUN this cycle
//   prescale  in   [7:0] compare value from CTRL[15:8]
//   tick      out  count == prescale while running
// ---------------------------------------------------------------------------
module apb_timer_prescaler
    import apb_timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       start,
    input  logic [7:0] prescale,
    output logic       tick
);

    logic [7:0] count;

    // A new prescale value takes effect at the next compare since the
    // comparison always uses the live register value.
    assign tick = run && (count == prescale);

    always_ff @(posedge clk) begin
        if (rst || start) begin
            count <= 8'd0;
        end else if (run) begin
            count <= tick ? 8'd0 : count + 8'd1;
        end
    end

endmodule

// File: rtl/apb_timer.sv
// ---------------------------------------------------------------------------
// apb_timer
// APB-attached down-counting timer with one-shot and periodic modes, an
// optional 8-bit prescaler and a level interrupt.
// Registers: 0x00 CTRL (EN, MODE, IE, PRESCALE[15:8]), 0x04 LOAD,
//            0x08 VALUE, 0x0C STATUS (FLAG, write-1-to-clear).
// Build option: define APB_TIMER_PRESCALE_EN to include the prescaler;
//               without it the timer ticks every clock in RUN and
//               CTRL[15:8] reads 0.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   psel     in   APB select
//   penable  in   APB enable phase
//   paddr    in   [31:0] APB address, bits [7:2] decoded
//   pwrite   in   1 = write
//   pwdata   in   [31:0] write data
//   prdata   out  [31:0] combinational read data
//   irq      out  FLAG & IE
// ---------------------------------------------------------------------------
module apb_timer
    import apb_timer_pkg::*;
#(
    parameter logic [31:0] LOAD_RST = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        psel,
    input  logic        penable,
    input  logic [31:0] paddr,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        irq
);

    timer_state_t state;
    timer_state_t state_next;

    logic        mode;
    logic        ie;
    logic        flag;
    logic [7:0]  prescale;
    logic [31:0] load;
    logic [31:0] value;

    logic [5:0]  reg_idx;
    logic        wr_commit;
    logic        wr_ctrl;
    logic        wr_load;
    logic        wr_value;
    logic        wr_status;
    logic        tick;
    logic        expire;
    logic        start;
    logic        unused_addr;

    assign reg_idx     = paddr[7:2];
    assign unused_addr = ^{paddr[31:8], paddr[1:0]};

    // Writes land only on the access (enable) phase edge
    assign wr_commit = psel & penable & pwrite;
    assign wr_ctrl   = wr_commit && (reg_idx == IDX_CTRL);
    assign wr_load   = wr_commit && (reg_idx == IDX_LOAD);
    assign wr_value  = wr_commit && (reg_idx == IDX_VALUE);
    assign wr_status = wr_commit && (reg_idx == IDX_STATUS);

    assign expire = tick && (value == 32'd0);

`ifdef APB_TIMER_PRESCALE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            prescale <= 8'd0;
        end else if (wr_ctrl) begin
            prescale <= pwdata[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB];
        end
    end

    apb_timer_prescaler u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .run      (state == ST_RUN),
        .start    (start),
        .prescale (prescale),
        .tick     (tick)
    );
`else
    logic unused_start;

    assign prescale     = 8'd0;
    assign tick         = (state == ST_RUN);
    assign unused_start = start;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_STOP;
        end else begin
            state <= state_next;
        end
    end

    // A CTRL write always decides the next state, even when a one-shot
    // expiry lands on the same edge.
    always_comb begin
        state_next = state;
        if (wr_ctrl) begin
            state_next = pwdata[CTRL_EN_BIT] ? ST_RUN : ST_STOP;
        end else if (expire && !mode) begin
            state_next = ST_STOP;
        end
    end

    assign start = (state == ST_STOP) && (state_next == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            mode <= 1'b0;
            ie   <= 1'b0;
        end else if (wr_ctrl) begin
            mode <= pwdata[CTRL_MODE_BIT];
            ie   <= pwdata[CTRL_IE_BIT];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load <= LOAD_RST;
        end else if (wr_load) begin
            load <= pwdata;
        end
    end

    // Software writes take priority over a tick on the same edge; a
    // one-shot expiry simply leaves VALUE parked at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= LOAD_RST;
        end else if (wr_load || wr_value) begin
            value <= pwdata;
        end else if (tick) begin
            if (value != 32'd0) begin
                value <= value - 32'd1;
            end else if (mode) begin
                value <= load;
            end
        end
    end

    // Expiry beats a simultaneous write-1-to-clear
    always_ff @(posedge clk) begin
        if (rst) begin
            flag <= 1'b0;
        end else if (expire) begin
            flag <= 1'b1;
        end else if (wr_status && pwdata[STATUS_FLAG_BIT]) begin
            flag <= 1'b0;
        end
    end

    assign irq = flag & ie;

    // Read data is driven through both APB phases so the bridge can
    // sample it during the enable phase.
    always_comb begin
        prdata = 32'd0;
        if (psel && !pwrite) begin
            case (reg_idx)
                IDX_CTRL:   prdata = pack_ctrl(state == ST_RUN, mode, ie, prescale);
                IDX_LOAD:   prdata = load;
                IDX_VALUE:  prdata = value;
                IDX_STATUS: prdata = {31'd0, flag};
                default:    prdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_timer.sv
// ---------------------------------------------------------------------------
// tb_apb_timer
// Self-checking bench for apb_timer. Expected values come from the timer's
// arithmetic rules: expiry after (LOAD+1)*(PRESCALE+1) clocks and VALUE
// equal to LOAD minus the number of whole prescale periods elapsed.
// Honours APB_TIMER_PRESCALE_EN so the same bench covers both builds.
// ---------------------------------------------------------------------------
module tb_apb_timer;
    import apb_timer_pkg::*;

    localparam logic [31:0] LOAD_RST = 32'hFFFF_FFFF;
`ifdef APB_TIMER_PRESCALE_EN
    localparam bit HAS_PS = 1'b1;
`else
    localparam bit HAS_PS = 1'b0;
`endif

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_LOAD   = 32'h04;
    localparam logic [31:0] A_VALUE  = 32'h08;
    localparam logic [31:0] A_STATUS = 32'h0C;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        irq;

    int pass_cnt  = 0;
    int total_cnt = 0;

    apb_timer #(.LOAD_RST(LOAD_RST)) dut (
        .clk     (clk),
        .rst     (rst),
        .psel    (psel),
        .penable (penable),
        .paddr   (paddr),
        .pwrite  (pwrite),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Prescale value the hardware actually uses in this build
    function automatic int eff_ps(input int p);
        return HAS_PS ? p : 0;
    endfunction

    task automatic wait_clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full two-phase APB write; returns 1 time unit after the commit edge
    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // Setup-phase-only read: samples the combinational read data without
    // consuming a clock
    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        #1;
        d = prdata;
        psel = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'd0; pwdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        total_cnt++; if (prdata !== 32'd0) $display("[TB] FAIL reset_prdata: got %h want %h", prdata, 32'd0); else pass_cnt++;
        total_cnt++; if (irq !== 1'b0) $display("[TB] FAIL reset_irq: got %b want 0", irq); else pass_cnt++;
        peek(A_CTRL, d);
        total_cnt++; if (d !== 32'd0) $display("[TB] FAIL reset_ctrl: got %h want %h", d, 32'd0); else pass_cnt++;
        peek(A_LOAD, d);
        total_cnt++; if (d !== LOAD_RST) $display("[TB] FAIL reset_load: got %h want %h", d, LOAD_RST); else pass_cnt++;
        peek(A_VALUE, d);
        total_cnt++; if (d !== LOAD_RST) $display("[TB] FAIL reset_value: got %h want %h", d, LOAD_RST); else pass_cnt++;
        peek(A_STATUS, d);
        total_cnt++; if (d !== 32'd0) $display("[TB] FAIL reset_status: got %h want %h", d, 32'd0); else pass_cnt++;
    endtask

    task automatic test_periodic();
        logic [31:0] d;
        int n;
        n = 4 * (eff_ps(2) + 1);
        apb_write(A_LOAD, 32'd3);
        apb_write(A_CTRL, 32'h0000_0207);
        wait_clocks(n - 1);
        peek(A_STATUS, d);
        total_cnt++; if (d !== 32'd0) $display("[TB] FAIL periodic_early_flag: got %h want 0 at clk %0d", d, n - 1); else pass_cnt++;
        total_cnt++; if (irq !== 1'b0) $display("[TB] FAIL periodic_early_irq: got %b want 0", irq); else pass_cnt++;
        wait_clocks(1);
        peek(A_STATUS, d);
        total_cnt++; if (d !== 32'd1) $display("[TB] FAIL periodic_flag: got %h want 1 at clk %0d", d, n); else pass_cnt++;
        total_cnt++; if (irq !== 1'b1) $display("[TB] FAIL periodic_irq: got %b want 1", irq); else pass_cnt++;
        peek(A_VALUE, d);
        total_cnt++; if (d !== 32'd3) $display("[TB] FAIL periodic_reload: got %h want 3", d); else pass_cnt++;
        apb_write(A_CTRL, 32'd0);
        apb_write(A_STATUS, 32'd1);
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        apb_write(A_LOAD, 32'd2);
        apb_write(A_CTRL, 32'h0000_0001);
        wait_clocks(2);
        peek(A_STATUS, d);
        total_cnt++; if (d !== 32'd0) $display("[TB] FAIL oneshot_early_flag: got %h want 0", d); else pass_cnt++;
        wait_clocks(1);
        peek(A_STATUS, d);
        total_cnt++; if (d !== 32'd1) $display("[TB] FAIL oneshot_flag: got %h want 1", d); else pass_cnt++;
        peek(A_CTRL, d);
        total_cnt++; if (d !== 32'd0) $display("[TB] FAIL oneshot_en_cleared: got %h want 0", d); else pass_cnt++;
        peek(A_VALUE, d);
        total_cnt++; if (d !== 32'd0) $display("[TB] FAIL oneshot_value: got %h want 0", d); else pass_cnt++;
        apb_write(A_STATUS, 32'd1);
        wait_clocks(10);
        peek(A_STATUS, d);
        total_cnt++; if (d !== 32'd0) $display("[TB] FAIL oneshot_no_reflag: got %h want 0", d); else pass_cnt++;
        peek(A_VALUE, d);
        total_cnt++; if (d !== 32'd0) $display("[TB] FAIL oneshot_value_hold: got %h want 0", d); else pass_cnt++;
    endtask

    task automatic test_read_timing();
        logic [31:0] d;
        apb_write(A_LOAD, 32'hDEAD_BEEF);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = A_LOAD;
        #1;
        total_cnt++; if (prdata !== 32'hDEAD_BEEF) $display("[TB] FAIL read_setup: got %h want %h", prdata, 32'hDEAD_BEEF); else pass_cnt++;
        @(negedge clk);
        penable = 1'b1;
        #1;
        total_cnt++; if (prdata !== 32'hDEAD_BEEF) $display("[TB] FAIL read_enable: got %h want %h", prdata, 32'hDEAD_BEEF); else pass_cnt++;
        @(posedge clk);
        #1;
        psel = 1'b0; penable = 1'b0;
        #1;
        total_cnt++; if (prdata !== 32'd0) $display("[TB] FAIL read_idle: got %h want 0", prdata); else pass_cnt++;
        peek(32'h40, d);
        total_cnt++; if (d !== 32'd0) $display("[TB] FAIL read_unmapped: got %h want 0", d); else pass_cnt++;
    endtask

    task automatic test_w1c_race();
        logic [31:0] d;
        apb_write(A_LOAD, 32'd2);
        apb_write(A_CTRL, 32'h0000_0005);
        wait_clocks(1);
        // Commit lands on the third edge after enabling: the expiry edge
        apb_write(A_STATUS, 32'd1);
        peek(A_STATUS, d);
        total_cnt++; if (d !== 32'd1) $display("[TB] FAIL w1c_race_flag: got %h want 1", d); else pass_cnt++;
        total_cnt++; if (irq !== 1'b1) $display("[TB] FAIL w1c_race_irq: got %b want 1", irq); else pass_cnt++;
        apb_write(A_STATUS, 32'd1);
        peek(A_STATUS, d);
        total_cnt++; if (d !== 32'd0) $display("[TB] FAIL w1c_clear_flag: got %h want 0", d); else pass_cnt++;
        total_cnt++; if (irq !== 1'b0) $display("[TB] FAIL w1c_clear_irq: got %b want 0", irq); else pass_cnt++;
    endtask

    task automatic test_write_qual();
        logic [31:0] d;
        logic [31:0] exp_ctrl;
        apb_write(A_CTRL, 32'd0);
        apb_write(A_LOAD, 32'h1234_5678);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_LOAD; pwdata = 32'hAAAA_5555;
        repeat (3) @(posedge clk);
        #1;
        psel = 1'b0; pwrite = 1'b0;
        peek(A_LOAD, d);
        total_cnt++; if (d !== 32'h1234_5678) $display("[TB] FAIL setup_only_load: got %h want %h", d, 32'h1234_5678); else pass_cnt++;
        peek(A_VALUE, d);
        total_cnt++; if (d !== 32'h1234_5678) $display("[TB] FAIL setup_only_value: got %h want %h", d, 32'h1234_5678); else pass_cnt++;
        apb_write(32'h10, 32'hFFFF_FFFF);
        peek(32'h10, d);
        total_cnt++; if (d !== 32'd0) $display("[TB] FAIL unmapped_write_read: got %h want 0", d); else pass_cnt++;
        peek(A_LOAD, d);
        total_cnt++; if (d !== 32'h1234_5678) $display("[TB] FAIL unmapped_write_load: got %h want %h", d, 32'h1234_5678); else pass_cnt++;
        peek(A_CTRL, d);
        total_cnt++; if (d !== 32'd0) $display("[TB] FAIL unmapped_write_ctrl: got %h want 0", d); else pass_cnt++;
        apb_write(A_CTRL, 32'hFFFF_AAF8);
        exp_ctrl = HAS_PS ? 32'h0000_AA00 : 32'h0000_0000;
        peek(A_CTRL, d);
        total_cnt++; if (d !== exp_ctrl) $display("[TB] FAIL ctrl_unused_bits: got %h want %h", d, exp_ctrl); else pass_cnt++;
        apb_write(A_CTRL, 32'd0);
    endtask

    task automatic test_write_priority();
        logic [31:0] d;
        apb_write(A_LOAD, 32'd50);
        apb_write(A_CTRL, 32'h0000_0003);
        wait_clocks(2);
        peek(A_VALUE, d);
        total_cnt++; if (d !== 32'd48) $display("[TB] FAIL prio_count: got %0d want 48", d); else pass_cnt++;
        apb_write(A_VALUE, 32'd100);
        peek(A_VALUE, d);
        total_cnt++; if (d !== 32'd100) $display("[TB] FAIL prio_value_write: got %0d want 100", d); else pass_cnt++;
        wait_clocks(1);
        peek(A_VALUE, d);
        total_cnt++; if (d !== 32'd99) $display("[TB] FAIL prio_after_write: got %0d want 99", d); else pass_cnt++;
        apb_write(A_LOAD, 32'd7);
        peek(A_VALUE, d);
        total_cnt++; if (d !== 32'd7) $display("[TB] FAIL prio_load_write: got %0d want 7", d); else pass_cnt++;
        apb_write(A_CTRL, 32'd0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        apb_write(A_STATUS, 32'd1);
        apb_write(A_LOAD, 32'd2);
        apb_write(A_CTRL, 32'h0000_0001);
        wait_clocks(1);
        // CTRL rewrite commits on the one-shot expiry edge
        apb_write(A_CTRL, 32'h0000_0001);
        peek(A_CTRL, d);
        total_cnt++; if (d !== 32'd1) $display("[TB] FAIL ctrl_vs_expiry_en: got %h want 1", d); else pass_cnt++;
        peek(A_STATUS, d);
        total_cnt++; if (d !== 32'd1) $display("[TB] FAIL ctrl_vs_expiry_flag: got %h want 1", d); else pass_cnt++;
        apb_write(A_CTRL, 32'd0);
        apb_write(A_STATUS, 32'd1);
    endtask

    task automatic test_reset_midcount();
        logic [31:0] d;
        apb_write(A_LOAD, 32'd5);
        apb_write(A_CTRL, 32'h0000_0007);
        peek(A_VALUE, d);
        total_cnt++; if (d !== 32'd5) $display("[TB] FAIL midreset_pre_value: got %0d want 5", d); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        peek(A_CTRL, d);
        total_cnt++; if (d !== 32'd0) $display("[TB] FAIL midreset_ctrl: got %h want 0", d); else pass_cnt++;
        peek(A_VALUE, d);
        total_cnt++; if (d !== LOAD_RST) $display("[TB] FAIL midreset_value: got %h want %h", d, LOAD_RST); else pass_cnt++;
        peek(A_LOAD, d);
        total_cnt++; if (d !== LOAD_RST) $display("[TB] FAIL midreset_load: got %h want %h", d, LOAD_RST); else pass_cnt++;
        total_cnt++; if (irq !== 1'b0) $display("[TB] FAIL midreset_irq: got %b want 0", irq); else pass_cnt++;
        wait_clocks(20);
        peek(A_STATUS, d);
        total_cnt++; if (d !== 32'd0) $display("[TB] FAIL midreset_no_flag: got %h want 0", d); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] exp_v;
        logic [31:0] exp_ctrl;
        int l, p, pe, n, k, j;
        bit mode, ie;
        for (int it = 0; it < 10; it++) begin
            l    = int'($urandom_range(0, 6));
            p    = int'($urandom_range(0, 3));
            mode = 1'($urandom_range(0, 1));
            ie   = 1'($urandom_range(0, 1));
            pe   = eff_ps(p);
            n    = (l + 1) * (pe + 1);
            apb_write(A_CTRL, 32'd0);
            apb_write(A_STATUS, 32'd1);
            apb_write(A_LOAD, 32'(l));
            apb_write(A_CTRL, {16'h0, 8'(p), 5'b0, ie, mode, 1'b1});
            k = int'($urandom_range(0, n - 1));
            wait_clocks(k);
            exp_v = 32'(l - k / (pe + 1));
            peek(A_VALUE, d);
            total_cnt++; if (d !== exp_v) $display("[TB] FAIL rand_mid_value it%0d: got %0d want %0d (L=%0d P=%0d k=%0d)", it, d, exp_v, l, p, k); else pass_cnt++;
            peek(A_STATUS, d);
            total_cnt++; if (d !== 32'd0) $display("[TB] FAIL rand_early_flag it%0d: got %h want 0", it, d); else pass_cnt++;
            wait_clocks(n - k);
            peek(A_STATUS, d);
            total_cnt++; if (d !== 32'd1) $display("[TB] FAIL rand_flag it%0d: got %h want 1 (L=%0d P=%0d)", it, d, l, p); else pass_cnt++;
            total_cnt++; if (irq !== ie) $display("[TB] FAIL rand_irq it%0d: got %b want %b", it, irq, ie); else pass_cnt++;
            exp_v = mode ? 32'(l) : 32'd0;
            peek(A_VALUE, d);
            total_cnt++; if (d !== exp_v) $display("[TB] FAIL rand_expiry_value it%0d: got %0d want %0d", it, d, exp_v); else pass_cnt++;
            exp_ctrl = {16'h0, 8'(pe), 5'b0, ie, mode, mode};
            peek(A_CTRL, d);
            total_cnt++; if (d !== exp_ctrl) $display("[TB] FAIL rand_ctrl it%0d: got %h want %h", it, d, exp_ctrl); else pass_cnt++;
            j = int'($urandom_range(0, n - 1));
            wait_clocks(j);
            exp_v = mode ? 32'(l - j / (pe + 1)) : 32'd0;
            peek(A_VALUE, d);
            total_cnt++; if (d !== exp_v) $display("[TB] FAIL rand_second_period it%0d: got %0d want %0d (j=%0d)", it, d, exp_v, j); else pass_cnt++;
        end
        apb_write(A_CTRL, 32'd0);
        apb_write(A_STATUS, 32'd1);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d/%0d", pass_cnt, total_cnt);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_read_timing();
        test_w1c_race();
        test_write_qual();
        test_write_priority();
        test_back_to_back();
        test_reset_midcount();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
